ifetch_ctrl: RTL and testbench

- Instruction-fetch controller that owns the program counter and sequences the combinational instruction ROM (word-indexed, 32-bit words, byte address in, instruction out in the same cycle).
- Selects next PC from sequential, ID-stage jump, or EX-stage branch/redirect; honours hazard-unit stalls; halts on EBREAK.
- Presents {pc, pc+4, inst, valid} to the external IF/ID pipeline register.

---
 rtl/ifetch_ctrl_if.sv | 28 ++
 rtl/ifetch_ctrl.sv | 112 +++++++++++
 tb/tb_ifetch_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: ROM address/data and the IF/ID bundle.
// master = ifetch_ctrl, slave = ROM plus IF/ID register.
interface ifetch_ctrl_if;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    modport master (
        output rom_addr_o,
        input  rom_inst_i,
        output if_pc_o,
        output if_pc4_o,
        output if_inst_o,
        output if_valid_o
    );

    modport slave (
        input  rom_addr_o,
        output rom_inst_i,
        input  if_pc_o,
        input  if_pc4_o,
        input  if_inst_o,
        input  if_valid_o
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC and sequences the ROM.
// Define IFETCH_PERF_CNT_EN to build the fetch/stall counters.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_AW      = 14,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_i,
    input  logic         id_jump_i,
    input  logic [31:0]  id_target_i,
    input  logic         ex_redirect_i,
    input  logic [31:0]  ex_target_i,
    input  logic         resume_i,
    ifetch_ctrl_if.master fif,
    output logic         halted_o,
    output logic         misalign_o,
    output logic         oob_o,
    output logic [31:0]  fetch_cnt_o,
    output logic [31:0]  stall_cnt_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc4;
    logic        mis_q, mis_d;
    logic        valid;

    assign pc4 = pc_q + 32'd4;

    // Next-PC select, state transitions and valid qualification.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        mis_d   = 1'b0;
        valid   = (state_q == RUN) && !ex_redirect_i && !id_jump_i;
        if (ex_redirect_i) begin
            pc_d    = ex_target_i & ~32'd3;
            mis_d   = |ex_target_i[1:0];
            state_d = RUN;
        end else if (id_jump_i) begin
            pc_d  = id_target_i & ~32'd3;
            mis_d = |id_target_i[1:0];
            if (state_q == BOOT) state_d = RUN;
        end else if (stall_i) begin
            if (state_q == BOOT) state_d = RUN;
        end else begin
            unique case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (fif.rom_inst_i == EBREAK_INST) state_d = HALT;
                    else pc_d = pc4;
                end
                HALT: begin
                    if (resume_i) begin
                        pc_d    = pc4;
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // PC, state and misalign pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= BOOT;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            mis_q   <= mis_d;
        end
    end

    assign fif.rom_addr_o = pc_q;
    assign fif.if_pc_o    = pc_q;
    assign fif.if_pc4_o   = pc4;
    assign fif.if_valid_o = valid;
    assign fif.if_inst_o  = valid ? fif.rom_inst_i : NOP;
    assign halted_o       = (state_q == HALT);
    assign misalign_o     = mis_q;
    assign oob_o          = |pc_q[31:ROM_AW+2];

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, scnt_q;

    // Count accepted fetches and hazard stalls seen while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 32'd0;
            scnt_q <= 32'd0;
        end else begin
            if (valid && !stall_i) fcnt_q <= fcnt_q + 32'd1;
            if (stall_i && state_q == RUN) scnt_q <= scnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fcnt_q;
    assign stall_cnt_o = scnt_q;
`else
    assign fetch_cnt_o = 32'd0;
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: spec-level model checked every cycle
// plus directed literal expectations.
module tb_ifetch_ctrl;
    localparam int          AW     = 14;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LIMIT  = 32'd4 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, jmp, redir, resume;
    logic [31:0] jt, rt;
    logic        halted, mis, oob;
    logic [31:0] fcnt, scnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [0:(1<<AW)-1];

    ifetch_ctrl_if fif ();

    ifetch_ctrl #(
        .RESET_PC   (32'h0),
        .ROM_AW     (AW),
        .EBREAK_INST(EBRK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .id_jump_i    (jmp),
        .id_target_i  (jt),
        .ex_redirect_i(redir),
        .ex_target_i  (rt),
        .resume_i     (resume),
        .fif          (fif.master),
        .halted_o     (halted),
        .misalign_o   (mis),
        .oob_o        (oob),
        .fetch_cnt_o  (fcnt),
        .stall_cnt_o  (scnt)
    );

    always #5 clk = ~clk;

    // ROM aliases on the low word-address bits.
    assign fif.rom_inst_i = rom[fif.rom_addr_o[AW+1:2]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: 0 = boot bubble, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_f, m_s;
    logic        m_mis;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [AW-1:0] w;
        w = a[AW+1:2];
        return rom[w];
    endfunction

    // Check every cycle against the model, then advance it.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ei;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_mis = 0; m_f = 0; m_s = 0;
        end
        ev = (m_mode == 1) && !redir && !jmp;
        ei = ev ? rom_word(m_pc) : NOP;
        chk("m_addr",   fif.rom_addr_o, m_pc);
        chk("m_pc",     fif.if_pc_o,    m_pc);
        chk("m_pc4",    fif.if_pc4_o,   m_pc + 32'd4);
        chk("m_inst",   fif.if_inst_o,  ei);
        chk("m_valid",  {31'd0, fif.if_valid_o}, {31'd0, ev});
        chk("m_halted", {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
        chk("m_mis",    {31'd0, mis},   {31'd0, m_mis});
        chk("m_oob",    {31'd0, oob},   (m_pc >= LIMIT) ? 32'd1 : 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("m_fcnt", fcnt, m_f);
        chk("m_scnt", scnt, m_s);
`else
        chk("m_fcnt", fcnt, 32'd0);
        chk("m_scnt", scnt, 32'd0);
`endif
        if (rst_n) begin
            if (ev && !stall) m_f = m_f + 1;
            if (stall && m_mode == 1) m_s = m_s + 1;
            m_mis = redir ? (rt[1:0] != 0) : (jmp && jt[1:0] != 0);
            if (redir) begin
                m_pc = {rt[31:2], 2'b00}; m_mode = 1;
            end else if (jmp) begin
                m_pc = {jt[31:2], 2'b00};
                if (m_mode == 0) m_mode = 1;
            end else if (stall) begin
                if (m_mode == 0) m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume) begin m_pc = m_pc + 4; m_mode = 1; end
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (rom_word(m_pc) == EBRK) begin
                m_mode = 2;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; jmp = 0; redir = 0; resume = 0;
        jt = 0; rt = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            rom[i] = 32'hA5A5_0000 | i;
        rom[8] = EBRK;
        clr();
        rst_n = 0;
        step(2);
        rst_n = 1;
        @(negedge clk);
        chk("boot_valid", {31'd0, fif.if_valid_o}, 32'd0);
        chk("boot_pc", fif.if_pc_o, 32'h0);
        step(1);
        @(negedge clk);
        chk("run_pc0", fif.if_pc_o, 32'h0);
        chk("run_inst0", fif.if_inst_o, 32'hA5A5_0000);
        step(4);
        stall = 1;
        @(negedge clk);
        chk("stall_pc", fif.if_pc_o, 32'h10);
        step(3);
        stall = 0;
        @(negedge clk);
        chk("stall_hold", fif.if_inst_o, 32'hA5A5_0004);
        step(1);
        @(negedge clk);
        chk("after_stall", fif.if_pc_o, 32'h14);
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_cnt3", scnt, 32'd3);
`endif
        step(3);
        @(negedge clk);
        chk("ebreak_inst", fif.if_inst_o, EBRK);
        chk("ebreak_valid", {31'd0, fif.if_valid_o}, 32'd1);
        step(1);
        @(negedge clk);
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", fif.if_pc_o, 32'h20);
        step(2);
        resume = 1;
        step(1);
        resume = 0;
        @(negedge clk);
        chk("resume_pc", fif.if_pc_o, 32'h24);
        chk("resume_run", {31'd0, halted}, 32'd0);
        jmp = 1; jt = 32'h40; redir = 1; rt = 32'h80; stall = 1;
        @(negedge clk);
        chk("prio_valid", {31'd0, fif.if_valid_o}, 32'd0);
        step(1);
        clr();
        @(negedge clk);
        chk("prio_pc", fif.if_pc_o, 32'h80);
        redir = 1; rt = 32'h102;
        step(1);
        clr();
        @(negedge clk);
        chk("mis_pc", fif.if_pc_o, 32'h100);
        chk("mis_pulse", {31'd0, mis}, 32'd1);
        step(1);
        @(negedge clk);
        chk("mis_clear", {31'd0, mis}, 32'd0);
        jmp = 1; jt = 32'h46;
        step(1);
        clr();
        @(negedge clk);
        chk("jmp_pc", fif.if_pc_o, 32'h44);
        redir = 1; rt = 32'h0001_0000;
        step(1);
        clr();
        @(negedge clk);
        chk("oob", {31'd0, oob}, 32'd1);
        chk("oob_alias", fif.if_inst_o, 32'hA5A5_0000);
        redir = 1; rt = 32'hFFFF_FFFC;
        step(1);
        clr();
        @(negedge clk);
        chk("wrap_pc4", fif.if_pc4_o, 32'h0);
        step(1);
        @(negedge clk);
        chk("wrap_pc", fif.if_pc_o, 32'h0);
        redir = 1; rt = 32'h20;
        step(1);
        clr();
        step(1);
        @(negedge clk);
        chk("halt2", {31'd0, halted}, 32'd1);
        step(1);
        rst_n = 0;
        #2;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", fif.if_pc_o, 32'h0);
        chk("rst_valid", {31'd0, fif.if_valid_o}, 32'd0);
        step(2);
        rst_n = 1;
        step(4);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
